clk_step_ctrl: RTL and testbench

Run/halt/single-step controller for the MIPS core's clock enable on the FPGA board. It holds a runtime-selectable divider and a debounced step button, and issues one-cycle CpuEn pulses. The core runs on Clk and gates every state update with CpuEn. This replaces free-running divided clocks with a single clock domain.

---
 rtl/clk_step_ctrl.sv | 162 ++++++++++++++++
 tb/tb_clk_step_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: run/halt/single-step controller that issues one-cycle CpuEn pulses to the core.
//
// Ports:
//   Clk        system clock, all logic on posedge
//   Rst        synchronous reset, active-low
//   DivSel     tick rate: 00 every Clk, 01 DIV_FAST, 10/11 DIV_SLOW
//   RunReq     level; a rising edge while halted starts free running
//   HaltReq    level; high forces HALT, overriding run and step
//   StepBtn    raw asynchronous push button, active-high
//   CpuEn      registered one-cycle enable to the core
//   Running    high while in RUN
//   StepCnt    count of CpuEn pulses issued, wraps
//   Halted     high while in HALT
//
// Optional build macro CLK_STEP_BREAK_EN adds the breakpoint ports
//   Pc, BreakAddr, BreakValid (inputs) and BreakHit (sticky output).
module clk_step_ctrl #(
    parameter int DIV_W    = 26,
    parameter int DIV_FAST = 5000000,
    parameter int DIV_SLOW = 50000000,
    parameter int DEB_CNT  = 1000000,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [1:0]       DivSel,
    input  logic             RunReq,
    input  logic             HaltReq,
    input  logic             StepBtn,
`ifdef CLK_STEP_BREAK_EN
    input  logic [31:0]      Pc,
    input  logic [31:0]      BreakAddr,
    input  logic             BreakValid,
    output logic             BreakHit,
`endif
    output logic             CpuEn,
    output logic             Running,
    output logic [CNT_W-1:0] StepCnt,
    output logic             Halted
);
    localparam logic [1:0] HALT      = 2'd0;
    localparam logic [1:0] RUN       = 2'd1;
    localparam logic [1:0] STEP_WAIT = 2'd2;
    localparam int         DEB_W     = $clog2(DEB_CNT + 1);

    logic [1:0]       state;
    logic [1:0]       nextState;
    logic             enNext;
    logic             stopRun;
    logic             runHold;
    logic [DIV_W-1:0] divCnt;
    logic [DIV_W-1:0] divLast;
    logic [1:0]       divSelQ;
    logic             selChg;
    logic             tick;
    logic             btnMeta;
    logic             btnSync;
    logic             debLevel;
    logic [DEB_W-1:0] debCnt;
    logic             stepPulse;
    logic             runReqD;
    logic             runRise;

    // Divider restarts from zero whenever the rate selection changes, so the
    // first tick at a new rate is always a full period away.
    always_comb begin
        divLast = DivSel == 2'b00 ? '0 :
                  DivSel == 2'b01 ? DIV_W'(DIV_FAST - 1) : DIV_W'(DIV_SLOW - 1);
        selChg  = DivSel != divSelQ;
        tick    = !selChg && divCnt == divLast;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            divCnt  <= '0;
            divSelQ <= 2'b00;
        end else begin
            divSelQ <= DivSel;
            divCnt  <= (selChg || tick) ? '0 : divCnt + DIV_W'(1);
        end
    end

    // Debounce counts consecutive cycles the synced button differs from the
    // accepted level; returning to the accepted level restarts the count.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            btnMeta   <= 1'b0;
            btnSync   <= 1'b0;
            debLevel  <= 1'b0;
            debCnt    <= '0;
            stepPulse <= 1'b0;
        end else begin
            btnMeta   <= StepBtn;
            btnSync   <= btnMeta;
            stepPulse <= 1'b0;
            if (btnSync == debLevel)
                debCnt <= '0;
            else if (debCnt == DEB_W'(DEB_CNT - 1)) begin
                debCnt    <= '0;
                debLevel  <= btnSync;
                stepPulse <= btnSync;
            end else
                debCnt <= debCnt + DEB_W'(1);
        end
    end

    assign runRise = RunReq & ~runReqD;
    assign stopRun = HaltReq || !RunReq;

`ifdef CLK_STEP_BREAK_EN
    logic breakMask;
    logic breakNow;

    // The breakpoint is judged on the pulse in flight: the core executes the
    // instruction at Pc while CpuEn is high. The first pulse after a resume
    // is exempt so the core can step off the breakpoint.
    assign breakNow = state == RUN && CpuEn && BreakValid && Pc == BreakAddr && !breakMask;
    assign runHold  = !stopRun && !breakNow;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            BreakHit  <= 1'b0;
            breakMask <= 1'b0;
        end else if (state == HALT && nextState == RUN) begin
            BreakHit  <= 1'b0;
            breakMask <= 1'b1;
        end else begin
            if (breakNow)
                BreakHit <= 1'b1;
            if (state == RUN && CpuEn)
                breakMask <= 1'b0;
        end
    end
`else
    assign runHold = !stopRun;
`endif

    // Run request beats a simultaneous step; a step seen outside HALT is dropped.
    always_comb begin
        nextState = state == HALT      ? (HaltReq ? HALT : runRise ? RUN : stepPulse ? STEP_WAIT : HALT) :
                    state == RUN       ? (runHold ? RUN : HALT) :
                    state == STEP_WAIT ? ((HaltReq || tick) ? HALT : STEP_WAIT) : HALT;
        enNext    = tick && ((state == RUN && runHold) || (state == STEP_WAIT && !HaltReq));
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= HALT;
            CpuEn   <= 1'b0;
            StepCnt <= '0;
            runReqD <= 1'b0;
        end else begin
            state   <= nextState;
            CpuEn   <= enNext;
            StepCnt <= StepCnt + CNT_W'(enNext);
            runReqD <= RunReq;
        end
    end

    assign Running = state == RUN;
    assign Halted  = state == HALT;
endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl: scoreboard bench for clk_step_ctrl; expected CpuEn pulses
// (cycle and StepCnt) are queued as stimulus is driven and matched on each pulse.
//
// Ports: none (top-level bench). Honours CLK_STEP_BREAK_EN to exercise the breakpoint.
module tb_clk_step_ctrl;
    localparam int DEB = 8;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } expT;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [1:0]  DivSel = 2'b00;
    logic        RunReq = 1'b0;
    logic        HaltReq = 1'b0;
    logic        StepBtn = 1'b0;
    logic        CpuEn;
    logic        Running;
    logic [15:0] StepCnt;
    logic        Halted;
`ifdef CLK_STEP_BREAK_EN
    logic [31:0] pc = 32'h0;
    logic [31:0] BreakAddr = 32'h0;
    logic        BreakValid = 1'b0;
    logic        BreakHit;
    logic        pcClr = 1'b0;
`endif

    int          cyc = 0;
    int          nChecks = 0;
    int          nPass = 0;
    int          lastSel = -100;
    int          curDiv = 1;
    logic [15:0] expCnt = 16'h0;
    expT         expQ[$];
    expT         monE;

    clk_step_ctrl #(
        .DIV_FAST(4),
        .DIV_SLOW(6),
        .DEB_CNT(DEB),
        .CNT_W(16)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .DivSel(DivSel),
        .RunReq(RunReq),
        .HaltReq(HaltReq),
        .StepBtn(StepBtn),
`ifdef CLK_STEP_BREAK_EN
        .Pc(pc),
        .BreakAddr(BreakAddr),
        .BreakValid(BreakValid),
        .BreakHit(BreakHit),
`endif
        .CpuEn(CpuEn),
        .Running(Running),
        .StepCnt(StepCnt),
        .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

`ifdef CLK_STEP_BREAK_EN
    // Stand-in for the core: Pc advances by one word per enabled cycle.
    always @(posedge Clk) pc <= pcClr ? 32'h00400000 : (CpuEn ? pc + 32'd4 : pc);
`endif

    task automatic check(input string tag, input longint got, input longint want);
        nChecks++;
        if (got == want)
            nPass++;
        else
            $display("FAIL %s: got %0d want %0d", tag, got, want);
    endtask

    always @(negedge Clk) begin
        if (CpuEn === 1'b1) begin
            if (expQ.size() == 0)
                check("unexpectedPulse", cyc, -1);
            else begin
                monE = expQ.pop_front();
                check("pulseCycle", cyc, monE.cyc);
                check("pulseCnt", StepCnt, monE.cnt);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic setDiv(input logic [1:0] sel, input int div);
        if (DivSel != sel) begin
            DivSel  = sel;
            lastSel = cyc;
        end
        curDiv = div;
    endtask

    // RunReq raised after edge k gives RUN from edge k+1 and a pulse at every
    // tick-qualified edge from k+2 up to the edge where RUN is left (s).
    task automatic pushRun(input int k, input int s);
        for (int p = k + 2; p <= s; p++)
            if (p >= lastSel + 1 + curDiv && (p - lastSel - 1) % curDiv == 0) begin
                expCnt++;
                expQ.push_back('{p, expCnt});
            end
    endtask

    task automatic runPhase(input int len);
        int k;
        k      = cyc;
        RunReq = 1'b1;
        pushRun(k, k + len);
        waitCycles(2);
        check("running", Running, 1);
        waitCycles(len - 2);
        RunReq = 1'b0;
        waitCycles(1);
        check("haltedAfterRun", Halted, 1);
        check("cpuEnAfterRun", CpuEn, 0);
        waitCycles(3);
        check("queueEmpty", expQ.size(), 0);
    endtask

    initial begin
        int k;
        int b;
        waitCycles(3);
        check("rstHalted", Halted, 1);
        check("rstRunning", Running, 0);
        check("rstCpuEn", CpuEn, 0);
        check("rstStepCnt", StepCnt, 0);
        Rst = 1'b1;
        waitCycles(2);

        runPhase(10);
        check("cntAfterFast", StepCnt, expCnt);

        setDiv(2'b01, 4);
        waitCycles(3);
        runPhase(40);

        setDiv(2'b10, 6);
        waitCycles(2);
        runPhase(30);

        setDiv(2'b00, 1);
        waitCycles(3);
        b = 0;
        for (int i = 0; i < 7; i++) begin
            StepBtn = (i % 2 == 0);
            if (i == 6) begin
                b = cyc;
                expCnt++;
                expQ.push_back('{b + DEB + 4, expCnt});
            end
            waitCycles(3);
        end
        waitCycles(30);
        check("stepHalted", Halted, 1);
        check("stepRunning", Running, 0);
        check("stepCnt", StepCnt, expCnt);
        check("stepQueueEmpty", expQ.size(), 0);
        StepBtn = 1'b0;
        waitCycles(15);

        k      = cyc;
        RunReq = 1'b1;
        pushRun(k, k + 6);
        waitCycles(6);
        HaltReq = 1'b1;
        waitCycles(1);
        check("haltReqHalted", Halted, 1);
        check("haltReqCpuEn", CpuEn, 0);
        waitCycles(2);
        HaltReq = 1'b0;
        waitCycles(3);
        check("noRestartWithoutEdge", Halted, 1);
        RunReq = 1'b0;
        waitCycles(2);
        check("haltQueueEmpty", expQ.size(), 0);

`ifdef CLK_STEP_BREAK_EN
        BreakAddr  = 32'h00400010;
        BreakValid = 1'b1;
        pcClr      = 1'b1;
        waitCycles(1);
        pcClr  = 1'b0;
        k      = cyc;
        RunReq = 1'b1;
        pushRun(k, k + 6);
        waitCycles(8);
        check("breakHalted", Halted, 1);
        check("breakHit", BreakHit, 1);
        check("breakPc", pc, 32'h00400014);
        RunReq = 1'b0;
        waitCycles(1);
        k      = cyc;
        RunReq = 1'b1;
        pushRun(k, k + 4);
        waitCycles(2);
        check("resumeHitClear", BreakHit, 0);
        check("resumeRunning", Running, 1);
        waitCycles(2);
        RunReq = 1'b0;
        waitCycles(3);
        check("resumePc", pc, 32'h00400020);
        check("breakQueueEmpty", expQ.size(), 0);
        BreakValid = 1'b0;
`endif

        runPhase(65535 - int'(expCnt) + 1);
        check("cntMax", StepCnt, 16'hFFFF);
        runPhase(2);
        check("cntWrap", StepCnt, 0);

        k      = cyc;
        RunReq = 1'b1;
        pushRun(k, k + 5);
        waitCycles(5);
        Rst = 1'b0;
        waitCycles(1);
        expCnt = 16'h0;
        check("midRstStepCnt", StepCnt, 0);
        check("midRstHalted", Halted, 1);
        check("midRstRunning", Running, 0);
        check("midRstCpuEn", CpuEn, 0);
        RunReq = 1'b0;
        Rst    = 1'b1;
        waitCycles(4);
        check("midRstQueueEmpty", expQ.size(), 0);
        check("midRstNoRestart", Halted, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
